// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_capture
// Purpose  : Receive side of a multiplexed 4-digit seven-segment display.
//            Synchronizes the anode-select and segment lines and waits for
//            each pattern to hold steady before accepting it. Accepted
//            glyphs are decoded back to 4-bit values and collected into
//            frames of four slots.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock        in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   AN           in   4  anode select, active-low one-hot (1110 = slot0)
//   segment_data in   7  segments, active-low, bit6 = a .. bit0 = g
//   digit0..3    out  4  last decoded value per slot
//   digit_err    out  4  per slot: last accepted glyph was undecodable
//   frame_valid  out  1  one-cycle pulse when all four slots are captured
//   scan_lost    out  1  set on timeout, cleared by the next accepted digit
//   order_err    out  1  sticky scan-order violation
// Build option:
//   SEVSEG_CAPTURE_ORDER_CHECK_EN - when defined, the slot order 0-1-2-3 is
//   tracked and order_err is driven; otherwise order_err is constant 0.
// ============================================================================
module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 131072,
  parameter int TO_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] AN,
  input  logic [6:0] segment_data,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       scan_lost,
  output logic       order_err
);

  localparam int            ST_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STABLE_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Returns {err, value}. 0110000 is the driver's blank/default glyph and
  // decodes to E without raising an error.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b1100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0110000: decode = 5'h0E;
      default:    decode = 5'h1F;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronizer and previous-sample register
  // --------------------------------------------------------------------------
  logic [3:0] an_s1, an_s2, an_prev;
  logic [6:0] seg_s1, seg_s2, seg_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      an_s1    <= 4'hF;
      an_s2    <= 4'hF;
      an_prev  <= 4'hF;
      seg_s1   <= 7'h7F;
      seg_s2   <= 7'h7F;
      seg_prev <= 7'h7F;
    end else begin
      an_s1    <= AN;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= segment_data;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  // --------------------------------------------------------------------------
  // Stability counter: counts consecutive identical samples, the first
  // sample of a new pattern counts as 1.
  // --------------------------------------------------------------------------
  logic [ST_W-1:0] stab_cnt;
  logic            same;
  logic            slot_valid;
  logic [1:0]      slot;
  logic [3:0]      slot_bit;
  logic            accept;
  logic [4:0]      dec;

  assign same = (an_s2 == an_prev) && (seg_s2 == seg_prev);

  always_ff @(posedge clock) begin
    if (reset) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= ST_W'(1);
    end else if (stab_cnt != ST_MAX) begin
      stab_cnt <= stab_cnt + ST_W'(1);
    end
  end

  always_comb begin
    slot_valid = 1'b1;
    slot       = 2'd0;
    case (an_s2)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot_valid = 1'b0;
    endcase
  end

  assign slot_bit = 4'b0001 << slot;
  // Fires only on the edge where the counter steps onto STABLE_CYCLES, so a
  // dwell is accepted once no matter how long it lasts.
  assign accept   = same && (stab_cnt == ST_LAST) && slot_valid;
  assign dec      = decode(seg_s2);

  // --------------------------------------------------------------------------
  // Captured digits
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      digit0    <= 4'h0;
      digit1    <= 4'h0;
      digit2    <= 4'h0;
      digit3    <= 4'h0;
      digit_err <= 4'h0;
    end else if (accept) begin
      case (slot)
        2'd0:    digit0 <= dec[3:0];
        2'd1:    digit1 <= dec[3:0];
        2'd2:    digit2 <= dec[3:0];
        default: digit3 <= dec[3:0];
      endcase
      digit_err[slot] <= dec[4];
    end
  end

  // --------------------------------------------------------------------------
  // Scan timeout; acceptance takes priority over an expiring counter.
  // --------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  assign timeout_hit = !accept && (to_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt    <= '0;
      scan_lost <= 1'b0;
    end else begin
      if (accept) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (accept) begin
        scan_lost <= 1'b0;
      end else if (timeout_hit) begin
        scan_lost <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  state_t     state, state_n;
  logic [3:0] mask, mask_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      mask  <= 4'h0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    if (timeout_hit) begin
      state_n = S_IDLE;
      mask_n  = 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_n = S_COLLECT;
            mask_n  = slot_bit;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            mask_n = mask | slot_bit;
            if (mask_n == 4'hF) begin
              state_n = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Mask restarts empty, but a digit accepted right now is kept.
          state_n = S_COLLECT;
          mask_n  = accept ? slot_bit : 4'h0;
        end
        default: begin
          state_n = S_IDLE;
          mask_n  = 4'h0;
        end
      endcase
    end
  end

  assign frame_valid = (state == S_DONE);

  // --------------------------------------------------------------------------
  // Optional scan-order checker
  // --------------------------------------------------------------------------
`ifdef SEVSEG_CAPTURE_ORDER_CHECK_EN
  logic [1:0] exp_slot;
  logic       seeded;
  logic       order_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_slot    <= 2'd0;
      seeded      <= 1'b0;
      order_err_q <= 1'b0;
    end else if (accept) begin
      seeded   <= 1'b1;
      exp_slot <= slot + 2'd1;
      if (seeded && (slot != exp_slot)) begin
        order_err_q <= 1'b1;
      end
    end else if (timeout_hit) begin
      // A lost scan means the next acceptance reseeds the expectation.
      seeded <= 1'b0;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_capture
// Purpose  : Self-checking bench for seven_segment_capture. Stimulus pushes
//            expected frames into a queue; a monitor pops and compares on
//            every frame_valid pulse. Directed checks cover single digits,
//            glitch rejection, decode errors, timeout, reset and ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;

  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int TO_W           = 9;
`ifdef SEVSEG_CAPTURE_ORDER_CHECK_EN
  localparam logic [31:0] ORDER_EXP = 32'd1;
`else
  localparam logic [31:0] ORDER_EXP = 32'd0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] AN;
  logic [6:0] segment_data;
  logic [3:0] digit0, digit1, digit2, digit3, digit_err;
  logic       frame_valid, scan_lost, order_err;

  seven_segment_capture #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .AN          (AN),
    .segment_data(segment_data),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_lost   (scan_lost),
    .order_err   (order_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN           = an;
    segment_data = seg;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame monitor
  always @(negedge clock) begin
    if (!reset && frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got frame_valid=1 expected no frame");
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        chk("frame_digits", {16'h0, digit3, digit2, digit1, digit0}, {16'h0, e.digits});
        chk("frame_err", {28'h0, digit_err}, {28'h0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    AN           = 4'hF;
    segment_data = 7'h7F;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
    chk("rst_err", {28'h0, digit_err}, 32'h0);
    chk("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_scan_lost", {31'h0, scan_lost}, 32'h0);
    chk("rst_order_err", {31'h0, order_err}, 32'h0);

    // Full ordered scan 0,1,2,3
    hold(4'b1110, 7'b0000001, 20);
    hold(4'b1101, 7'b1001111, 20);
    hold(4'b1011, 7'b0010010, 20);
    exp_q.push_back('{digits: 16'h3210, err: 4'h0});
    hold(4'b0111, 7'b0000110, 20);
    chk("scan1_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h3210);
    chk("scan1_err", {28'h0, digit_err}, 32'h0);

    // Glitch in a slot1 dwell restarts the stability count
    hold(4'b1101, 7'b0100100, 4);
    hold(4'b1101, 7'b0100101, 1);
    hold(4'b1101, 7'b0100100, 4);
    chk("glitch_not_yet", {28'h0, digit1}, 32'h1);
    hold(4'b1101, 7'b0100100, 12);
    chk("glitch_accepted", {28'h0, digit1}, 32'h5);

    // A 5-cycle dwell is too short to be accepted
    hold(4'b1110, 7'b1001111, 5);

    // Default glyph and undecodable glyph on slot2
    hold(4'b1011, 7'b0110000, 20);
    chk("short_dwell_digit0", {28'h0, digit0}, 32'h0);
    chk("blank_glyph_digit2", {28'h0, digit2}, 32'hE);
    chk("blank_glyph_err", {31'h0, digit_err[2]}, 32'h0);
    hold(4'b1011, 7'b1111110, 20);
    chk("bad_glyph_digit2", {28'h0, digit2}, 32'hF);
    chk("bad_glyph_err", {31'h0, digit_err[2]}, 32'h1);
    hold(4'b1110, 7'b0000000, 20);
    exp_q.push_back('{digits: 16'h9F58, err: 4'b0100});
    hold(4'b0111, 7'b0000100, 20);

    // Timeout after one accepted digit clears the partial frame
    hold(4'b1110, 7'b1001111, 20);
    hold(4'b1111, 7'h7F, 250);
    chk("scan_lost_before_timeout", {31'h0, scan_lost}, 32'h0);
    hold(4'b1111, 7'h7F, 200);
    chk("scan_lost_after_timeout", {31'h0, scan_lost}, 32'h1);
    hold(4'b1101, 7'b0001111, 20);
    chk("scan_lost_cleared", {31'h0, scan_lost}, 32'h0);
    hold(4'b1011, 7'b1100000, 20);
    hold(4'b0111, 7'b1001100, 20);
    exp_q.push_back('{digits: 16'h4672, err: 4'h0});
    hold(4'b1110, 7'b0010010, 20);

    // Reset after three captured slots discards the partial frame
    hold(4'b1110, 7'b0000110, 20);
    hold(4'b1101, 7'b0000000, 20);
    hold(4'b1011, 7'b0000100, 20);
    hold(4'b1111, 7'h7F, 3);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_rst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
    chk("mid_rst_err", {28'h0, digit_err}, 32'h0);
    chk("mid_rst_scan_lost", {31'h0, scan_lost}, 32'h0);
    chk("mid_rst_order_err", {31'h0, order_err}, 32'h0);

    // Out-of-order scan 0,1,3,2
    hold(4'b1110, 7'b0000001, 20);
    hold(4'b1101, 7'b1001111, 20);
    chk("order_ok", {31'h0, order_err}, 32'h0);
    hold(4'b0111, 7'b0001111, 20);
    chk("order_violation", {31'h0, order_err}, ORDER_EXP);
    exp_q.push_back('{digits: 16'h7210, err: 4'h0});
    hold(4'b1011, 7'b0010010, 20);
    chk("order_sticky", {31'h0, order_err}, ORDER_EXP);

    hold(4'b1111, 7'h7F, 20);
    chk("frames_pending", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit seven-segment display driver.
- Samples the anode-select (AN, active-low one-hot) and segment lines (active-low, segment a in bit 6).
- Requires each pattern to be stable before accepting it, decodes glyphs back to 4-bit values, and rebuilds the displayed frame.
- Used for self-check and loopback of display output, e.g. digits returned over the UART.

Parameters:
STABLE_CYCLES, 8, consecutive identical synchronized samples needed to accept a digit (minimum 2)
TIMEOUT_CYCLES, 131072, cycles without an accepted digit before the scan is declared lost
TO_W, 18, width of the timeout counter (must satisfy 2^TO_W > TIMEOUT_CYCLES)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
AN  input  4  anode select, active-low; valid slots 1110=slot0, 1101=slot1, 1011=slot2, 0111=slot3
segment_data  input  7  segment pattern, active-low, bit6=a .. bit0=g
digit0..digit3  output  4 each  last decoded value per slot
digit_err  output  4  per-slot flag: last accepted glyph was undecodable
frame_valid  output  1  one-cycle pulse when all four slots have been captured since the last frame
scan_lost  output  1  level; set on timeout, cleared on the next accepted digit
order_err  output  1  sticky scan-order violation (optional feature only; otherwise tied 0)

Behaviour:
- Reset (synchronous, active-high, sampled on the clock edge):
  - digit0..3=0, digit_err=0, frame_valid=0, scan_lost=0, order_err=0.
  - Slot mask, stability counter and timeout counter cleared; sync stages cleared to AN=1111, seg=1111111.
  - Asserting reset mid-capture discards any partial frame.
- Input path: 2-flop synchronizer on all 11 input bits, then a 1-stage "previous sample" register.
- Stability:
  - Counter increments while the synchronized sample equals the previous sample and saturates at STABLE_CYCLES.
  - Any change reloads the counter to 1 and re-arms acceptance.
- Acceptance:
  - A digit is accepted exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES, and only if AN is one of the four valid slot codes.
  - AN=1111, 0000 or multiple lows are never accepted. They do not clear the mask; they do count toward timeout.
- Decode table, seg to value:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 1100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 0110000=4'hE, the driver's default glyph; err=0.
  - Any other pattern = 4'hF with err=1.
- Latency:
  - digitN and digit_err[N] update on the acceptance edge.
  - Acceptance occurs 2 (sync) + STABLE_CYCLES cycles after the input change at the earliest.
- Frame state machine:
  - States IDLE, COLLECT, DONE, with a 4-bit slot mask.
  - IDLE to COLLECT on the first accepted digit.
  - COLLECT: set mask bit per accepted slot; re-capturing a slot overwrites its value and leaves the mask unchanged.
  - Mask becomes 1111: go to DONE and pulse frame_valid for 1 cycle.
  - DONE to COLLECT next cycle, with the mask cleared.
  - If acceptance coincides with the mask clear, the new slot's bit is kept.
- Timeout:
  - Counter cleared on every acceptance.
  - Reaching TIMEOUT_CYCLES sets scan_lost, clears the mask and returns to IDLE. The counter then holds and does not wrap.
  - scan_lost clears on the cycle of the next acceptance.
- Simultaneous timeout and acceptance: acceptance wins; the counter clears and scan_lost stays 0.

Optional Feature:
- Macro: SEVSEG_CAPTURE_ORDER_CHECK_EN.
- Defined:
  - The expected next slot is tracked as 0→1→2→3→0, seeded by the first acceptance after reset or after scan_lost.
  - An accepted slot that differs from the expected slot sets order_err (sticky until reset) and reseeds the expectation from that slot.
  - Repeated acceptance of the same slot with no intervening pattern change is impossible by design, so it is not checked.
- Not defined: order_err is a constant 0 and no tracking logic is built.

Test Plan:
- Drive AN=1110/seg=0000001, AN=1101/1001111, AN=1011/0010010, AN=0111/0000110, 20 cycles each → digit0..3=0,1,2,3; digit_err=0000; exactly one frame_valid pulse, 1 cycle after slot3 acceptance.
- AN=1101, seg=0100100 held for STABLE_CYCLES+1 = 9 cycles with one glitch to 0100101 at cycle 4 → acceptance delayed until 8 stable samples after the glitch; a 5-cycle dwell is never accepted.
- Slot2 seg=0110000 → digit2=4'hE with err=0; then seg=1111110 → digit2=4'hF, digit_err[2]=1.
- AN=1111 held for 131072 cycles after one accepted digit → scan_lost=1 and the mask cleared; the next valid dwell clears scan_lost, and no frame_valid occurs until all four slots are re-captured.
- Assert reset for 1 cycle after 3 slots captured → all outputs 0; a new full scan is needed for frame_valid.
- With SEVSEG_CAPTURE_ORDER_CHECK_EN: scan order 0,1,3,2 → order_err=1 on slot3 acceptance and held; without the macro, order_err=0 throughout.
